// File: rtl/affine_pkg.sv
// Shared types for the affine controller interface: index width, index type,
// error cause encoding and the lexicographic "next point" helper.
package affine_pkg;

    localparam int unsigned AFFINE_IDX_W = 16;

    typedef logic [AFFINE_IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_SEQ     = 2'd1,
        ERR_OVERRUN = 2'd2,
        ERR_BOUNDS  = 2'd3
    } err_code_e;

    // A point of the 2-D iteration domain, y outer, x inner.
    typedef struct packed {
        idx_t y;
        idx_t x;
    } point_t;

    // Successor of (y, x) in lexicographic order; x wraps at last_x.
    // An out-of-domain x (> last_x) just increments, so a resync from a bad
    // tuple still yields a deterministic expectation.
    function automatic point_t next_point(input idx_t y, input idx_t x, input idx_t last_x);
        point_t p;
        if (x == last_x) begin
            p.x = '0;
            p.y = y + idx_t'(1);
        end else begin
            p.x = x + idx_t'(1);
            p.y = y;
        end
        return p;
    endfunction

endpackage

// File: rtl/affine_seq_tracker.sv
// Sequence tracker for the affine index stream: holds the expected next point,
// flags out-of-order tuples (resyncing from the received tuple), flags tuples
// arriving after the domain end, raises a sticky done and counts valid tuples.
// Error outputs are single-cycle pulses for the tuple currently on valid_i;
// the first-error latch lives in the parent.
module affine_seq_tracker
    import affine_pkg::*;
#(
    parameter int unsigned EXT_Y = 64,
    parameter int unsigned EXT_X = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        valid_i,
    input  idx_t [2:0]  d_i,
    output logic        done_o,
    output logic        seq_err_o,
    output logic        overrun_o,
    output logic [31:0] consumed_o
);

    localparam idx_t LastY = idx_t'(EXT_Y - 1);
    localparam idx_t LastX = idx_t'(EXT_X - 1);

    point_t      exp_q, exp_d;
    logic        done_q, done_d;
    logic [31:0] consumed_q, consumed_d;

    // Next-state for the pointer, done and count; error pulses for this tuple.
    always_comb begin
        exp_d      = exp_q;
        done_d     = done_q;
        consumed_d = consumed_q;
        seq_err_o  = 1'b0;
        overrun_o  = 1'b0;
        if (flush_i) begin
            exp_d      = '0;
            done_d     = 1'b0;
            consumed_d = '0;
        end else if (valid_i) begin
            if (consumed_q != 32'hFFFF_FFFF) begin
                consumed_d = consumed_q + 32'd1;
            end
            if (done_q) begin
                overrun_o = 1'b1;
            end else begin
                if ((d_i[0] != '0) || (d_i[1] != exp_q.y) || (d_i[2] != exp_q.x)) begin
                    seq_err_o = 1'b1;
                end
                if ((d_i[1] == LastY) && (d_i[2] == LastX)) begin
                    done_d = 1'b1;
                end
                // Advance from what was received, not from the old expectation.
                exp_d = next_point(d_i[1], d_i[2], LastX);
            end
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q      <= '0;
            done_q     <= 1'b0;
            consumed_q <= '0;
        end else begin
            exp_q      <= exp_d;
            done_q     <= done_d;
            consumed_q <= consumed_d;
        end
    end

    assign done_o     = done_q;
    assign consumed_o = consumed_q;

endmodule

// File: rtl/affine_index_consumer.sv
// Receiving end of the affine controller interface. Each valid index tuple is
// turned into a linear buffer address OFFSET + STRIDE_Y*y + STRIDE_X*x through
// a 2-stage pipeline, while affine_seq_tracker checks the stream walks the
// 2-D domain once in lexicographic order. err/err_code hold the first error.
// Optional build macro AFFINE_INDEX_CONSUMER_BOUNDS_CHECK_EN: compare the full
// 32-bit address against BUF_DEPTH, drop out-of-range entries, report code 3.
module affine_index_consumer
    import affine_pkg::*;
#(
    parameter int unsigned EXT_Y     = 64,
    parameter int unsigned EXT_X     = 64,
    parameter int unsigned STRIDE_Y  = 64,
    parameter int unsigned STRIDE_X  = 1,
    parameter int unsigned OFFSET    = 0,
    parameter int unsigned AW        = 16,
    parameter int unsigned BUF_DEPTH = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  idx_t [2:0]    d_in,
    input  logic          valid_in,
    output logic [AW-1:0] addr_out,
    output logic          addr_valid,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [31:0]   consumed
);

    // Stage 1 registers.
    logic      s1_valid_q, s1_valid_d;
    idx_t      s1_y_q, s1_y_d;
    idx_t      s1_x_q, s1_x_d;

    // Stage 2 (output) registers.
    logic [AW-1:0] addr_q, addr_d;
    logic          addr_valid_q, addr_valid_d;

    // First-error latch.
    logic      err_q, err_d;
    err_code_e err_code_q, err_code_d;

    logic        seq_err;
    logic        overrun;
    logic [31:0] addr_full;
    logic        bounds_bad;
    logic        bounds_err;

    affine_seq_tracker #(
        .EXT_Y (EXT_Y),
        .EXT_X (EXT_X)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .valid_i    (valid_in),
        .d_i        (d_in),
        .done_o     (done),
        .seq_err_o  (seq_err),
        .overrun_o  (overrun),
        .consumed_o (consumed)
    );

    // Unsigned 32-bit products and sum; truncation to AW happens at emission.
    assign addr_full = OFFSET + (STRIDE_Y * 32'(s1_y_q)) + (STRIDE_X * 32'(s1_x_q));

`ifdef AFFINE_INDEX_CONSUMER_BOUNDS_CHECK_EN
    assign bounds_bad = (addr_full >= BUF_DEPTH);
`else
    logic unused_cfg;
    assign bounds_bad = 1'b0;
    assign unused_cfg = ^{addr_full, BUF_DEPTH};
`endif

    assign bounds_err = s1_valid_q && bounds_bad;

    // Stage 1 capture; coordinates only follow valid tuples.
    always_comb begin
        s1_valid_d = valid_in && !flush;
        s1_y_d     = s1_y_q;
        s1_x_d     = s1_x_q;
        if (valid_in) begin
            s1_y_d = d_in[1];
            s1_x_d = d_in[2];
        end
    end

    // Stage 2: emit the address unless flushed or out of bounds; addr_out holds otherwise.
    always_comb begin
        addr_d       = addr_q;
        addr_valid_d = 1'b0;
        if (s1_valid_q && !bounds_bad && !flush) begin
            addr_d       = addr_full[AW-1:0];
            addr_valid_d = 1'b1;
        end
    end

    // Keep only the first error; same-cycle priority overrun > sequence > bounds.
    always_comb begin
        err_d      = err_q;
        err_code_d = err_code_q;
        if (flush) begin
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
        end else if (!err_q) begin
            if (overrun) begin
                err_d      = 1'b1;
                err_code_d = ERR_OVERRUN;
            end else if (seq_err) begin
                err_d      = 1'b1;
                err_code_d = ERR_SEQ;
            end else if (bounds_err) begin
                err_d      = 1'b1;
                err_code_d = ERR_BOUNDS;
            end
        end
    end

    // Pipeline and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_y_q       <= '0;
            s1_x_q       <= '0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_y_q       <= s1_y_d;
            s1_x_q       <= s1_x_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign addr_out   = addr_q;
    assign addr_valid = addr_valid_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: doc/affine_index_consumer.md
Name: affine_index_consumer

Overview:
- Receiving end of the affine controller interface: consumes one controller's index tuple d[2:0] plus valid.
- Turns each valid tuple into a linear buffer address (offset + stride·index) through a 2-stage pipeline.
- In parallel, checks that the incoming tuple stream walks the 2-D iteration domain in lexicographic order, exactly once.
- Sits between an affine_controller instance and a unified-buffer port; raises done at end of domain and a sticky error on any protocol violation.

Parameters:
- EXT_Y, 64, extent of outer dim (d[1]); legal values 0..EXT_Y-1
- EXT_X, 64, extent of inner dim (d[2]); legal values 0..EXT_X-1
- STRIDE_Y, 64, address stride of d[1]
- STRIDE_X, 1, address stride of d[2]
- OFFSET, 0, base address
- AW, 16, address width
- BUF_DEPTH, 4096, buffer words; used only by the optional bounds check

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- flush  in  1  sync clear of tracker/pipeline state
- d_in  in  16x3  index tuple; d_in[0]=root, d_in[1]=y, d_in[2]=x
- valid_in  in  1  tuple valid this cycle
- addr_out  out  AW  linear address
- addr_valid  out  1  addr_out valid
- done  out  1  sticky: full domain consumed
- err  out  1  sticky error flag
- err_code  out  2  first error cause: 0 none, 1 sequence, 2 overrun, 3 bounds
- consumed  out  32  count of accepted valid tuples

Behaviour:
- Reset rst_n is asynchronous, active-low; clock is clk.
- Reset values: addr_out=0, addr_valid=0, done=0, err=0, err_code=0, consumed=0, exp_y=exp_x=0, all pipeline valids 0.
- d_in is don't-care when valid_in=0 (the controller drives 0xAAAA pre-start). It must never be compared or latched into the tracker when invalid.
- Pipeline:
  - S1 registers d_in[1], d_in[2], valid_in.
  - S2 computes addr_out = OFFSET + STRIDE_Y·y + STRIDE_X·x, truncated mod 2^AW; multiplies are unsigned 32-bit, then truncated.
  - addr_valid asserts exactly 2 cycles after valid_in, one cycle per input.
  - Back-to-back valids give back-to-back addresses. No stall input; the block accepts every cycle.
- Address emission on bad tuples: a tuple flagged by the sequence check still produces an address.
- Tracker, evaluated on valid_in:
  - Before done: the tuple is legal iff d_in[0]==0 && d_in[1]==exp_y && d_in[2]==exp_x.
  - After a legal tuple: exp_x+1; at exp_x==EXT_X-1 wrap exp_x to 0 and increment exp_y.
  - Accepting (EXT_Y-1, EXT_X-1) sets done the next cycle.
- Sequence error: an illegal tuple sets err with code 1.
  - Resync: the expected pointer advances from the received tuple (received value + 1, with wrap), not from the old expectation.
- Overrun: valid_in while done=1 sets err with code 2; the tuple still produces an address.
- consumed increments on every valid_in, saturating at 2^32-1.
- Error capture: err_code latches the first error only; later errors are ignored until flush/reset. Same-cycle priority is overrun > sequence > bounds.
- flush (synchronous, wins over same-cycle valid_in):
  - clears tracker, done, err, err_code, consumed, S1/S2 valids;
  - addr_out keeps its value.
- Reset mid-stream: everything returns to reset values. The next accepted tuple must be (0,0); otherwise code 1.

Optional Feature:
- Macro: AFFINE_INDEX_CONSUMER_BOUNDS_CHECK_EN.
- Defined:
  - S2 compares the untruncated 32-bit address against BUF_DEPTH.
  - addr >= BUF_DEPTH suppresses addr_valid for that entry and sets err with code 3 (if first error).
- Undefined: no comparison; code 3 is never produced; BUF_DEPTH is unused.

Decomposition:
- Shared package affine_pkg:
  - idx_t (16-bit index) typedef;
  - err_code_e enum (ERR_NONE, ERR_SEQ, ERR_OVERRUN, ERR_BOUNDS);
  - AFFINE_IDX_W=16 constant.
- One natural sub-module, affine_seq_tracker: expected-pointer, done, sequence/overrun detection, consumed count.
- The address pipeline stays in the top.

Test Plan:
- Nominal, defaults:
  - Stimulus: 4096 consecutive tuples (0,y,x) in order.
  - Expect addr_out = 64y+x two cycles after each input, first addr 0, last addr 4095.
  - done=1 the cycle after S1 of the last tuple; err=0; consumed=4096.
- Gapped input, EXT_Y=EXT_X=4:
  - Stimulus: valid every other cycle.
  - Expect 16 addr_valid pulses, spaced 2 cycles apart, addresses 0,1,2,3,64,…,195 (STRIDE_Y=64); done asserts.
- Skip:
  - Stimulus: after (0,0,0),(0,0,1), send (0,0,3).
  - Expect err=1, err_code=1, addr 3 still emitted; next (0,0,4) accepted without a new error code.
- Overrun, EXT 2x2:
  - Stimulus: send 5 tuples.
  - Expect done after the 4th; 5th sets err_code=2; consumed=5.
- Flush mid-stream:
  - Stimulus: flush at tuple 10, then restart at (0,0,0).
  - Expect err=0, done=0, consumed restarts at 1, no addr_valid for the 2 in-flight entries.
- Bounds (macro defined, BUF_DEPTH=100):
  - Stimulus: tuple (0,1,40) → addr 104.
  - Expect no addr_valid, err_code=3.
  - With the macro undefined: addr_valid=1, addr 104.
